// File: rtl/zap_regf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zap_regf_pkg
// Description : Shared constants and types for the register-file read/write
//               scheduler: FSM state encodings, read-port count and the
//               anti-starvation write-burst limit.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package zap_regf_pkg;

    // Number of addresses gathered into one read batch.
    localparam int c_rd_ports = 4;

    // Consecutive write grants tolerated during ISSUE before one read slot
    // is forced through.
    localparam logic [1:0] c_starve_limit = 2'd3;

    // Scheduler state encodings.
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_ISSUE = c_st_issue,
        ST_WAIT  = c_st_wait
    } state_t;

endpackage : zap_regf_pkg
`default_nettype wire

// File: rtl/zap_regf_sched.sv
`default_nettype none
// ============================================================================
// Module      : zap_regf_sched
// Description : Schedules a 4-address read batch and single-cycle writes onto
//               one dual-port RAM (port a = read/write, port b = write only).
//               Writes pass straight through to the RAM and win over read
//               issue; a 2-bit burst counter forces one read slot through
//               after three back-to-back write grants.
// Ports       : i_clk_2x, i_reset_n (async, active low)
//               read batch  : i_rd_valid/o_rd_ready, i_rd_addr_0..3,
//                             o_rd_data_0..3, o_rd_done
//               write       : i_wr_valid/o_wr_ready, i_wr_en_a/b,
//                             i_wr_addr_a/b, i_wr_data_a/b
//               RAM side    : o_bram_addr_a/b, o_bram_wen,
//                             o_bram_wr_data_a/b, i_bram_rd_data
// Config      : ZAP_REGF_FWD_EN - when defined, writes granted while a batch
//               is in flight also update already-issued slots so the batch
//               result reflects every write granted before o_rd_done.
// Revision    : 1.0 - initial release
// ============================================================================
module zap_regf_sched
    import zap_regf_pkg::*;
#(
    parameter int DATA_WDT = 32,
    parameter int ADDR_WDT = 6
) (
    input  logic                i_clk_2x,
    input  logic                i_reset_n,
    input  logic                i_rd_valid,
    output logic                o_rd_ready,
    input  logic [ADDR_WDT-1:0] i_rd_addr_0,
    input  logic [ADDR_WDT-1:0] i_rd_addr_1,
    input  logic [ADDR_WDT-1:0] i_rd_addr_2,
    input  logic [ADDR_WDT-1:0] i_rd_addr_3,
    output logic [DATA_WDT-1:0] o_rd_data_0,
    output logic [DATA_WDT-1:0] o_rd_data_1,
    output logic [DATA_WDT-1:0] o_rd_data_2,
    output logic [DATA_WDT-1:0] o_rd_data_3,
    output logic                o_rd_done,
    input  logic                i_wr_valid,
    output logic                o_wr_ready,
    input  logic                i_wr_en_a,
    input  logic                i_wr_en_b,
    input  logic [ADDR_WDT-1:0] i_wr_addr_a,
    input  logic [ADDR_WDT-1:0] i_wr_addr_b,
    input  logic [DATA_WDT-1:0] i_wr_data_a,
    input  logic [DATA_WDT-1:0] i_wr_data_b,
    output logic [ADDR_WDT-1:0] o_bram_addr_a,
    output logic [ADDR_WDT-1:0] o_bram_addr_b,
    output logic                o_bram_wen,
    output logic [DATA_WDT-1:0] o_bram_wr_data_a,
    output logic [DATA_WDT-1:0] o_bram_wr_data_b,
    input  logic [DATA_WDT-1:0] i_bram_rd_data
);

    state_t              r_state;
    logic [1:0]          r_idx;
    logic [1:0]          r_starve;
    logic [ADDR_WDT-1:0] r_addr [c_rd_ports];
    logic [DATA_WDT-1:0] r_data [c_rd_ports];
    logic                r_cap_vld;   // RAM output this cycle belongs to a slot
    logic [1:0]          r_cap_idx;   // ... and this is the slot
    logic                r_rd_done;

    logic                w_wr_ready;
    logic                w_wr_grant;
    logic                w_issue;
    logic [ADDR_WDT-1:0] w_bram_addr_a;
    logic [ADDR_WDT-1:0] w_bram_addr_b;
    logic                w_bram_wen;
    logic [DATA_WDT-1:0] w_bram_wr_data_a;
    logic [DATA_WDT-1:0] w_bram_wr_data_b;

    // Ready outputs are gated by the reset pin itself so they read 0 for the
    // whole time reset is held and 1 from the instant it is released.
    assign w_wr_ready = i_reset_n &
                        ~((r_state == ST_ISSUE) && (r_starve == c_starve_limit));
    assign w_wr_grant = i_wr_valid & w_wr_ready;
    assign w_issue    = (r_state == ST_ISSUE) & ~w_wr_grant;

    assign o_rd_ready = i_reset_n & (r_state == ST_IDLE);
    assign o_wr_ready = w_wr_ready;
    assign o_rd_done  = r_rd_done;

    assign o_rd_data_0 = r_data[0];
    assign o_rd_data_1 = r_data[1];
    assign o_rd_data_2 = r_data[2];
    assign o_rd_data_3 = r_data[3];

    // RAM port steering. A single enabled write port is mirrored onto both
    // RAM ports; with both enabled on one address, port a carries data_b so
    // the stored value is data_b regardless of the RAM's collision policy.
    always_comb begin
        w_bram_wen       = 1'b0;
        w_bram_addr_a    = '0;
        w_bram_addr_b    = '0;
        w_bram_wr_data_a = '0;
        w_bram_wr_data_b = '0;
        if (w_wr_grant) begin
            case ({i_wr_en_a, i_wr_en_b})
                2'b11: begin
                    w_bram_wen       = 1'b1;
                    w_bram_addr_a    = i_wr_addr_a;
                    w_bram_addr_b    = i_wr_addr_b;
                    w_bram_wr_data_a = (i_wr_addr_a == i_wr_addr_b) ? i_wr_data_b
                                                                    : i_wr_data_a;
                    w_bram_wr_data_b = i_wr_data_b;
                end
                2'b10: begin
                    w_bram_wen       = 1'b1;
                    w_bram_addr_a    = i_wr_addr_a;
                    w_bram_addr_b    = i_wr_addr_a;
                    w_bram_wr_data_a = i_wr_data_a;
                    w_bram_wr_data_b = i_wr_data_a;
                end
                2'b01: begin
                    w_bram_wen       = 1'b1;
                    w_bram_addr_a    = i_wr_addr_b;
                    w_bram_addr_b    = i_wr_addr_b;
                    w_bram_wr_data_a = i_wr_data_b;
                    w_bram_wr_data_b = i_wr_data_b;
                end
                default: begin
                    // No enables: the write is consumed without touching RAM.
                end
            endcase
        end else if (w_issue) begin
            w_bram_addr_a = r_addr[r_idx];
        end
    end

    assign o_bram_wen       = w_bram_wen;
    assign o_bram_addr_a    = w_bram_addr_a;
    assign o_bram_addr_b    = w_bram_addr_b;
    assign o_bram_wr_data_a = w_bram_wr_data_a;
    assign o_bram_wr_data_b = w_bram_wr_data_b;

`ifdef ZAP_REGF_FWD_EN
    logic [c_rd_ports-1:0] r_issued;
    logic                  w_fwd_live;
    assign w_fwd_live = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
`endif

    always_ff @(posedge i_clk_2x or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= 2'd0;
            r_starve  <= 2'd0;
            r_cap_vld <= 1'b0;
            r_cap_idx <= 2'd0;
            r_rd_done <= 1'b0;
            for (int k = 0; k < c_rd_ports; k++) begin
                r_addr[k] <= '0;
                r_data[k] <= '0;
            end
`ifdef ZAP_REGF_FWD_EN
            r_issued  <= '0;
`endif
        end else begin
            r_rd_done <= 1'b0;
            r_cap_vld <= w_issue;
            r_cap_idx <= r_idx;
            r_starve  <= ((r_state == ST_ISSUE) && w_wr_grant) ? r_starve + 2'd1
                                                               : 2'd0;

            // RAM data is one cycle behind the address it answers.
            if (r_cap_vld) begin
                r_data[r_cap_idx] <= i_bram_rd_data;
            end

`ifdef ZAP_REGF_FWD_EN
            // Placed after the capture so a write granted on a slot's
            // capture edge overrides the stale RAM value; port b last so it
            // wins when both ports hit the same slot.
            if (w_issue) begin
                r_issued[r_idx] <= 1'b1;
            end
            if (w_fwd_live && w_bram_wen) begin
                for (int k = 0; k < c_rd_ports; k++) begin
                    if (r_issued[k] && (w_bram_addr_a == r_addr[k])) begin
                        r_data[k] <= w_bram_wr_data_a;
                    end
                    if (r_issued[k] && (w_bram_addr_b == r_addr[k])) begin
                        r_data[k] <= w_bram_wr_data_b;
                    end
                end
            end
`endif

            case (r_state)
                ST_IDLE: begin
                    if (i_rd_valid) begin
                        r_addr[0] <= i_rd_addr_0;
                        r_addr[1] <= i_rd_addr_1;
                        r_addr[2] <= i_rd_addr_2;
                        r_addr[3] <= i_rd_addr_3;
                        r_idx     <= 2'd0;
                        r_state   <= ST_ISSUE;
`ifdef ZAP_REGF_FWD_EN
                        r_issued  <= '0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_state   <= ST_IDLE;
                    r_rd_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : zap_regf_sched
`default_nettype wire

// File: tb/tb_zap_regf_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_zap_regf_sched
// Description : Self-checking bench for zap_regf_sched with a behavioural
//               dual-port RAM (registered read on port a, port b written
//               last). Expected read data comes from a shadow copy of RAM
//               contents maintained from the writes the bench issues.
// Config      : ZAP_REGF_FWD_EN selects forwarding expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zap_regf_sched;

    localparam int DW = 32;
    localparam int AW = 6;
`ifdef ZAP_REGF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          ram_init;
    logic          rd_valid, rd_ready, rd_done;
    logic [AW-1:0] rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3;
    logic [DW-1:0] rd_data_0, rd_data_1, rd_data_2, rd_data_3;
    logic          wr_valid, wr_ready, wr_en_a, wr_en_b;
    logic [AW-1:0] wr_addr_a, wr_addr_b;
    logic [DW-1:0] wr_data_a, wr_data_b;
    logic [AW-1:0] bram_addr_a, bram_addr_b;
    logic          bram_wen;
    logic [DW-1:0] bram_wr_data_a, bram_wr_data_b, bram_rd_data;

    int total = 0;
    int bad   = 0;

    typedef logic [3:0][DW-1:0] res_t;
    res_t sb_q[$];

    typedef struct {
        logic [3:0][AW-1:0] addr;
        int                 wr_cyc;   // cycle after accept carrying one write (0 = none)
        logic [AW-1:0]      wr_addr;
        logic [DW-1:0]      wr_data;
        bit                 storm;    // hold i_wr_valid high (no-op writes) all batch
        int                 lat;      // edges from accept to o_rd_done
    } vec_t;

    vec_t vecs[5];
    logic [DW-1:0] shadow [64];
    logic [DW-1:0] mem [64];

    zap_regf_sched #(.DATA_WDT(DW), .ADDR_WDT(AW)) dut (
        .i_clk_2x         (clk),
        .i_reset_n        (rst_n),
        .i_rd_valid       (rd_valid),
        .o_rd_ready       (rd_ready),
        .i_rd_addr_0      (rd_addr_0),
        .i_rd_addr_1      (rd_addr_1),
        .i_rd_addr_2      (rd_addr_2),
        .i_rd_addr_3      (rd_addr_3),
        .o_rd_data_0      (rd_data_0),
        .o_rd_data_1      (rd_data_1),
        .o_rd_data_2      (rd_data_2),
        .o_rd_data_3      (rd_data_3),
        .o_rd_done        (rd_done),
        .i_wr_valid       (wr_valid),
        .o_wr_ready       (wr_ready),
        .i_wr_en_a        (wr_en_a),
        .i_wr_en_b        (wr_en_b),
        .i_wr_addr_a      (wr_addr_a),
        .i_wr_addr_b      (wr_addr_b),
        .i_wr_data_a      (wr_data_a),
        .i_wr_data_b      (wr_data_b),
        .o_bram_addr_a    (bram_addr_a),
        .o_bram_addr_b    (bram_addr_b),
        .o_bram_wen       (bram_wen),
        .o_bram_wr_data_a (bram_wr_data_a),
        .o_bram_wr_data_b (bram_wr_data_b),
        .i_bram_rd_data   (bram_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] f_init(input int i);
        if (i == 9) return 32'hAA;
        return 32'(i) * 32'h11;
    endfunction

    // RAM model: port b written after port a so b wins on equal addresses.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= f_init(i);
        end else if (bram_wen) begin
            mem[bram_addr_a] <= bram_wr_data_a;
            mem[bram_addr_b] <= bram_wr_data_b;
        end
        bram_rd_data <= mem[bram_addr_a];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                                input int wc, input int wa, input logic [DW-1:0] wd,
                                input bit st, input int lat);
        vec_t v;
        v.addr    = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
        v.wr_cyc  = wc;
        v.wr_addr = AW'(wa);
        v.wr_data = wd;
        v.storm   = st;
        v.lat     = lat;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wr();
        wr_valid = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0;
        wr_addr_a = '0; wr_addr_b = '0; wr_data_a = '0; wr_data_b = '0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        res_t exp_r;
        res_t got;
        int   lat   = -1;
        bit   seen  = 1'b0;
        int   lows  = 0;
        int   wens  = 0;
        int   issue;
        for (int k = 0; k < 4; k++) begin
            exp_r[k] = shadow[v.addr[k]];
            if (v.wr_cyc > 0 && v.addr[k] == v.wr_addr) begin
                // Slot k issues in cycle k+1, pushed back one by a write before it.
                issue = (k + 1 < v.wr_cyc) ? k + 1 : k + 2;
                if (issue > v.wr_cyc || FWD) exp_r[k] = v.wr_data;
            end
        end
        if (v.wr_cyc > 0) shadow[v.wr_addr] = v.wr_data;

        rd_valid  = 1'b1;
        rd_addr_0 = v.addr[0]; rd_addr_1 = v.addr[1];
        rd_addr_2 = v.addr[2]; rd_addr_3 = v.addr[3];
        if (v.storm) wr_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_rd_ready"}, 64'(rd_ready), 64'd1);
        sb_q.push_back(exp_r);
        cyc();
        rd_valid = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (c == v.wr_cyc) begin
                wr_valid = 1'b1; wr_en_a = 1'b1;
                wr_addr_a = v.wr_addr; wr_data_a = v.wr_data;
            end else if (!v.storm) begin
                idle_wr();
            end
            @(negedge clk);
            if (c == v.wr_cyc) chk({nm, "_inj_wr_ready"}, 64'(wr_ready), 64'd1);
            if (v.storm && !wr_ready) lows++;
            if (v.storm && bram_wen) wens++;
            if (rd_done) begin
                seen = 1'b1;
                lat  = c - 1;
                got  = {rd_data_3, rd_data_2, rd_data_1, rd_data_0};
            end
            cyc();
        end
        idle_wr();
        chk({nm, "_latency"}, 64'(lat), 64'(v.lat));
        if (v.storm) begin
            chk({nm, "_wr_ready_low_cycles"}, 64'(lows), 64'd4);
            chk({nm, "_noop_wen"}, 64'(wens), 64'd0);
        end
        if (seen) begin
            exp_r = sb_q.pop_front();
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s_data%0d", nm, k), 64'(got[k]), 64'(exp_r[k]));
            @(negedge clk);
            chk({nm, "_done_pulse"}, 64'(rd_done), 64'd0);
            chk({nm, "_data0_hold"}, 64'(rd_data_0), 64'(exp_r[0]));
            cyc();
        end else begin
            void'(sb_q.pop_back());
        end
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; ram_init = 1'b1; rd_valid = 1'b0;
        rd_addr_0 = '0; rd_addr_1 = '0; rd_addr_2 = '0; rd_addr_3 = '0;
        idle_wr();
        for (int i = 0; i < 64; i++) shadow[i] = f_init(i);

        vecs[0] = mk(1, 2, 3, 4,     0, 0, '0, 1'b0, 5);
        vecs[1] = mk(5, 7, 10, 11,   0, 0, '0, 1'b0, 5);
        vecs[2] = mk(9, 13, 9, 14,   2, 9, 32'hBB, 1'b0, 6);
        vecs[3] = mk(12, 12, 20, 63, 0, 0, '0, 1'b1, 17);
        vecs[4] = mk(0, 63, 7, 9,    5, 63, 32'h5A5A, 1'b0, 5);

        // Reset state.
        cyc(); cyc();
        @(negedge clk);
        chk("rst_rd_ready", 64'(rd_ready), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_rd_done",  64'(rd_done),  64'd0);
        chk("rst_rd_data0", 64'(rd_data_0), 64'd0);
        chk("rst_bram_wen", 64'(bram_wen), 64'd0);
        cyc();
        rst_n = 1'b1; ram_init = 1'b0;
        @(negedge clk);
        chk("post_rst_rd_ready", 64'(rd_ready), 64'd1);
        chk("post_rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("idle_bram_addr_a",  64'(bram_addr_a), 64'd0);

        // Write a only: mirrored onto both RAM ports.
        cyc();
        wr_valid = 1'b1; wr_en_a = 1'b1; wr_addr_a = 6'd5; wr_data_a = 32'hDEAD;
        wr_addr_b = 6'd33; wr_data_b = 32'hBAD;
        @(negedge clk);
        chk("wa_wen",    64'(bram_wen), 64'd1);
        chk("wa_addr_a", 64'(bram_addr_a), 64'd5);
        chk("wa_addr_b", 64'(bram_addr_b), 64'd5);
        chk("wa_data_a", 64'(bram_wr_data_a), 64'hDEAD);
        chk("wa_data_b", 64'(bram_wr_data_b), 64'hDEAD);
        shadow[5] = 32'hDEAD;

        // Both enables, same address: data_b must end up stored.
        cyc();
        wr_en_a = 1'b1; wr_en_b = 1'b1; wr_addr_a = 6'd7; wr_addr_b = 6'd7;
        wr_data_a = 32'h1; wr_data_b = 32'h2;
        @(negedge clk);
        chk("wab_same_wen", 64'(bram_wen), 64'd1);
        shadow[7] = 32'h2;

        // b only.
        cyc();
        wr_en_a = 1'b0; wr_en_b = 1'b1; wr_addr_a = 6'd40; wr_addr_b = 6'd10;
        wr_data_a = 32'h9999; wr_data_b = 32'h1234;
        @(negedge clk);
        chk("wb_addr_a", 64'(bram_addr_a), 64'd10);
        chk("wb_data_a", 64'(bram_wr_data_a), 64'h1234);
        shadow[10] = 32'h1234;

        // Both enables, different addresses.
        cyc();
        wr_en_a = 1'b1; wr_en_b = 1'b1; wr_addr_a = 6'd11; wr_addr_b = 6'd12;
        wr_data_a = 32'h0B0B; wr_data_b = 32'h0C0C;
        @(negedge clk);
        chk("wab_addr_a", 64'(bram_addr_a), 64'd11);
        chk("wab_addr_b", 64'(bram_addr_b), 64'd12);
        chk("wab_data_b", 64'(bram_wr_data_b), 64'h0C0C);
        shadow[11] = 32'h0B0B;
        shadow[12] = 32'h0C0C;

        // Neither enable: consumed as a no-op.
        cyc();
        wr_en_a = 1'b0; wr_en_b = 1'b0; wr_addr_a = 6'd11; wr_data_a = 32'hFFFF;
        @(negedge clk);
        chk("wnone_wr_ready", 64'(wr_ready), 64'd1);
        chk("wnone_wen",      64'(bram_wen), 64'd0);
        cyc();
        idle_wr();
        cyc();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while slot 2 is being issued: batch abandoned.
        rd_valid = 1'b1;
        rd_addr_0 = 6'd1; rd_addr_1 = 6'd2; rd_addr_2 = 6'd3; rd_addr_3 = 6'd4;
        cyc();
        rd_valid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_ready", 64'(rd_ready), 64'd0);
        chk("mid_rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("mid_rst_rd_done",  64'(rd_done),  64'd0);
        chk("mid_rst_data",     64'(rd_data_0 | rd_data_1 | rd_data_2 | rd_data_3), 64'd0);
        chk("mid_rst_bram",     64'(bram_addr_a) | 64'(bram_wen), 64'd0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rd_ready", 64'(rd_ready), 64'd1);
        chk("rel_wr_ready", 64'(wr_ready), 64'd1);
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rd_done) dones++;
        end
        chk("abandoned_no_done", 64'(dones), 64'd0);
        cyc();

        run_vec(vecs[0], "after_rst");
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_zap_regf_sched
`default_nettype wire
